// File: rtl/axil_master_queued.sv
// AXI4-Lite master with independent write/read command queues. Each direction issues one
// transaction at a time, returns a done pulse, and flags responses that exceed TIMEOUT cycles.
module axil_master_queued #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT        = 1024,
  localparam int unsigned LW            = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned SW            = AXI_DATA_WIDTH / 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  // Write command side
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0] wr_data,
  input  logic [SW-1:0]             wr_strb,
  output logic                      wr_done,
  output logic [1:0]                wr_error,
  output logic                      wr_timeout,
  output logic [LW-1:0]             wr_level,
  // Read command side
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_done,
  output logic [1:0]                rd_error,
  output logic                      rd_timeout,
  output logic [LW-1:0]             rd_level,
  // AXI-Lite master
  output logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_axil_wdata,
  output logic [SW-1:0]             m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WEW = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + SW;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {WIdle, WIssue, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RIssue, RResp} rd_state_e;

  // ---------------------------------------------------------------- write queue
  logic [WEW-1:0] wq_mem [FIFO_DEPTH];
  logic [PW-1:0]  wq_wptr_q, wq_rptr_q;
  logic [LW-1:0]  wq_level_q;
  logic           wq_push, wq_pop, wq_empty;
  logic [WEW-1:0] wq_head;

  assign wr_ready = (wq_level_q != LW'(FIFO_DEPTH));
  assign wq_empty = (wq_level_q == '0);
  assign wq_push  = wr_valid && wr_ready;
  assign wq_head  = wq_mem[wq_rptr_q];
  assign wr_level = wq_level_q;

  always_ff @(posedge aclk) begin
    if (wq_push) wq_mem[wq_wptr_q] <= {wr_addr, wr_data, wr_strb};
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wq_wptr_q  <= '0;
      wq_rptr_q  <= '0;
      wq_level_q <= '0;
    end else begin
      if (wq_push) wq_wptr_q <= wq_wptr_q + PW'(1);
      if (wq_pop)  wq_rptr_q <= wq_rptr_q + PW'(1);
      if (wq_push && !wq_pop)      wq_level_q <= wq_level_q + LW'(1);
      else if (!wq_push && wq_pop) wq_level_q <= wq_level_q - LW'(1);
    end
  end

  // ---------------------------------------------------------------- read queue
  logic [AXI_ADDR_WIDTH-1:0] rq_mem [FIFO_DEPTH];
  logic [PW-1:0]             rq_wptr_q, rq_rptr_q;
  logic [LW-1:0]             rq_level_q;
  logic                      rq_push, rq_pop, rq_empty;

  assign rd_ready = (rq_level_q != LW'(FIFO_DEPTH));
  assign rq_empty = (rq_level_q == '0);
  assign rq_push  = rd_valid && rd_ready;
  assign rd_level = rq_level_q;

  always_ff @(posedge aclk) begin
    if (rq_push) rq_mem[rq_wptr_q] <= rd_addr;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rq_wptr_q  <= '0;
      rq_rptr_q  <= '0;
      rq_level_q <= '0;
    end else begin
      if (rq_push) rq_wptr_q <= rq_wptr_q + PW'(1);
      if (rq_pop)  rq_rptr_q <= rq_rptr_q + PW'(1);
      if (rq_push && !rq_pop)      rq_level_q <= rq_level_q + LW'(1);
      else if (!rq_push && rq_pop) rq_level_q <= rq_level_q - LW'(1);
    end
  end

  // ---------------------------------------------------------------- write FSM
  wr_state_e                 wr_state_q, wr_state_d;
  logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]             wstrb_q, wstrb_d;
  logic                      wr_done_q, wr_done_d, wr_timeout_q, wr_tinc;
  logic [1:0]                wr_error_q, wr_error_d;
  logic [TW-1:0]             wr_tcnt_q;

  always_comb begin
    wr_state_d = wr_state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wr_done_d  = 1'b0;
    wr_error_d = wr_error_q;
    wq_pop     = 1'b0;
    unique case (wr_state_q)
      WIdle: begin
        if (!wq_empty) begin
          wq_pop                       = 1'b1;
          {awaddr_d, wdata_d, wstrb_d} = wq_head;
          awvalid_d                    = 1'b1;
          wvalid_d                     = 1'b1;
          wr_state_d                   = WIssue;
        end
      end
      WIssue: begin
        // AW and W retire independently; move on once both are gone.
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) wr_state_d = WResp;
      end
      WResp: begin
        if (m_axil_bvalid) begin
          wr_error_d = m_axil_bresp;
          wr_done_d  = 1'b1;
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  assign wr_tinc = TO_EN && (wr_state_q != WIdle) && (wr_tcnt_q != TO_MAX);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q   <= WIdle;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wr_done_q    <= 1'b0;
      wr_error_q   <= '0;
      wr_tcnt_q    <= '0;
      wr_timeout_q <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wr_done_q    <= wr_done_d;
      wr_error_q   <= wr_error_d;
      if (wq_pop)       wr_tcnt_q <= '0;
      else if (wr_tinc) wr_tcnt_q <= wr_tcnt_q + TW'(1);
      wr_timeout_q <= wr_tinc && (wr_tcnt_q == TO_LAST);
    end
  end

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = (wr_state_q == WResp);
  assign wr_done        = wr_done_q;
  assign wr_error       = wr_error_q;
  assign wr_timeout     = wr_timeout_q;

  // ---------------------------------------------------------------- read FSM
  rd_state_e                 rd_state_q, rd_state_d;
  logic                      arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      rd_done_q, rd_done_d, rd_timeout_q, rd_tinc;
  logic [1:0]                rd_error_q, rd_error_d;
  logic [TW-1:0]             rd_tcnt_q;

  always_comb begin
    rd_state_d = rd_state_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    rd_data_d  = rd_data_q;
    rd_error_d = rd_error_q;
    rd_done_d  = 1'b0;
    rq_pop     = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        if (!rq_empty) begin
          rq_pop     = 1'b1;
          araddr_d   = rq_mem[rq_rptr_q];
          arvalid_d  = 1'b1;
          rd_state_d = RIssue;
        end
      end
      RIssue: begin
        if (m_axil_arready) begin
          arvalid_d  = 1'b0;
          rd_state_d = RResp;
        end
      end
      RResp: begin
        if (m_axil_rvalid) begin
          rd_data_d  = m_axil_rdata;
          rd_error_d = m_axil_rresp;
          rd_done_d  = 1'b1;
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  assign rd_tinc = TO_EN && (rd_state_q != RIdle) && (rd_tcnt_q != TO_MAX);

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q   <= RIdle;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rd_data_q    <= '0;
      rd_error_q   <= '0;
      rd_done_q    <= 1'b0;
      rd_tcnt_q    <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rd_data_q    <= rd_data_d;
      rd_error_q   <= rd_error_d;
      rd_done_q    <= rd_done_d;
      if (rq_pop)       rd_tcnt_q <= '0;
      else if (rd_tinc) rd_tcnt_q <= rd_tcnt_q + TW'(1);
      rd_timeout_q <= rd_tinc && (rd_tcnt_q == TO_LAST);
    end
  end

  assign m_axil_araddr  = araddr_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = (rd_state_q == RResp);
  assign rd_data        = rd_data_q;
  assign rd_error       = rd_error_q;
  assign rd_done        = rd_done_q;
  assign rd_timeout     = rd_timeout_q;

endmodule
